// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer.
//   - 5-bit opcode values as they appear in IR[31:27]
//   - state encoding of the T-step sequencer
//   - instruction classes produced by the opcode decoder
//   - ALU operation codes driven on alu_op (ALU_NONE is the idle value)
package cpu_ctrl_pkg;

  localparam int OPW = 5;

  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPW-1:0] OP_SHRA = 5'b01000;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01001;
  localparam logic [OPW-1:0] OP_ROR  = 5'b01010;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01011;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T1W  = 4'd3,
    ST_T2   = 4'd4,
    ST_T3   = 4'd5,
    ST_T4   = 4'd6,
    ST_T5   = 4'd7,
    ST_T6   = 4'd8,
    ST_HALT = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU3   = 3'd0,
    CL_ALU2   = 3'd1,
    CL_MULDIV = 3'd2,
    CL_NOP    = 3'd3,
    CL_HALT   = 3'd4,
    CL_ILL    = 3'd5
  } op_class_t;

  localparam int ALU_CODE_W = 4;

  localparam logic [ALU_CODE_W-1:0] ALU_NONE = 4'd0;
  localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 4'd1;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB  = 4'd2;
  localparam logic [ALU_CODE_W-1:0] ALU_AND  = 4'd3;
  localparam logic [ALU_CODE_W-1:0] ALU_OR   = 4'd4;
  localparam logic [ALU_CODE_W-1:0] ALU_SHR  = 4'd5;
  localparam logic [ALU_CODE_W-1:0] ALU_SHRA = 4'd6;
  localparam logic [ALU_CODE_W-1:0] ALU_SHL  = 4'd7;
  localparam logic [ALU_CODE_W-1:0] ALU_ROR  = 4'd8;
  localparam logic [ALU_CODE_W-1:0] ALU_ROL  = 4'd9;
  localparam logic [ALU_CODE_W-1:0] ALU_MUL  = 4'd10;
  localparam logic [ALU_CODE_W-1:0] ALU_DIV  = 4'd11;
  localparam logic [ALU_CODE_W-1:0] ALU_NEG  = 4'd12;
  localparam logic [ALU_CODE_W-1:0] ALU_NOT  = 4'd13;
  localparam logic [ALU_CODE_W-1:0] ALU_INC  = 4'd14;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder.
// Maps the 5-bit opcode to an instruction class (which selects the
// execute-step sequence) and to the ALU operation used when Zin is asserted.
// Ports:
//   opcode   in  5   IR[31:27]
//   op_class out     instruction class (ALU3, ALU2, MULDIV, NOP, HALT, ILL)
//   op_alu   out 4   ALU operation for this opcode (ALU_NONE if none)
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_t  op_class,
  output logic [3:0] op_alu
);

  always_comb begin
    op_class = CL_ILL;
    op_alu   = ALU_NONE;
    case (opcode)
      OP_ADD:  begin op_class = CL_ALU3;   op_alu = ALU_ADD;  end
      OP_SUB:  begin op_class = CL_ALU3;   op_alu = ALU_SUB;  end
      OP_AND:  begin op_class = CL_ALU3;   op_alu = ALU_AND;  end
      OP_OR:   begin op_class = CL_ALU3;   op_alu = ALU_OR;   end
      OP_SHR:  begin op_class = CL_ALU3;   op_alu = ALU_SHR;  end
      OP_SHRA: begin op_class = CL_ALU3;   op_alu = ALU_SHRA; end
      OP_SHL:  begin op_class = CL_ALU3;   op_alu = ALU_SHL;  end
      OP_ROR:  begin op_class = CL_ALU3;   op_alu = ALU_ROR;  end
      OP_ROL:  begin op_class = CL_ALU3;   op_alu = ALU_ROL;  end
      OP_MUL:  begin op_class = CL_MULDIV; op_alu = ALU_MUL;  end
      OP_DIV:  begin op_class = CL_MULDIV; op_alu = ALU_DIV;  end
      OP_NEG:  begin op_class = CL_ALU2;   op_alu = ALU_NEG;  end
      OP_NOT:  begin op_class = CL_ALU2;   op_alu = ALU_NOT;  end
      OP_NOP:  op_class = CL_NOP;
      OP_HALT: op_class = CL_HALT;
      default: op_class = CL_ILL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer for the datapath.
// Walks the fetch steps (T0, T1, optional T1W memory wait, T2) and then the
// execute steps T3..T6 chosen by the decoded opcode class. All outputs are a
// Moore function of the current state and the IR opcode field.
// Ports:
//   clk       in  1       rising-edge clock
//   clr       in  1       asynchronous active-low reset
//   IR        in  IRW     instruction register (opcode field valid from T3)
//   mem_rdy   in  1       memory read data valid
//   Stop      in  1       halt request, honoured at the last step of an instruction
//   PCout..LOin out 1     datapath strobes
//   Gra/Grb/Grc out 1     register field selects (one-hot or idle)
//   Rin/Rout  out 1       load / drive of the selected register
//   alu_op    out ALUOPW  ALU operation, ALU_NONE whenever Zin is low
//   Run       out 1       high outside RST and HALT
//   illegal   out 1       high in T3 of an undefined opcode
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int IRW             = 32,
  parameter int ALUOPW          = 4,
  parameter int HALT_ON_ILLEGAL = 0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [IRW-1:0]    IR,
  input  logic              mem_rdy,
  input  logic              Stop,
  output logic              PCout,
  output logic              MARin,
  output logic              IncPC,
  output logic              Zin,
  output logic              Zlowout,
  output logic              Zhighout,
  output logic              PCin,
  output logic              Read,
  output logic              MDRin,
  output logic              MDRout,
  output logic              IRin,
  output logic              Yin,
  output logic              HIin,
  output logic              LOin,
  output logic              Gra,
  output logic              Grb,
  output logic              Grc,
  output logic              Rin,
  output logic              Rout,
  output logic [ALUOPW-1:0] alu_op,
  output logic              Run,
  output logic              illegal
);

  state_t     state;
  state_t     state_next;
  state_t     end_next;
  op_class_t  op_class;
  logic [3:0] op_alu;
  logic [4:0] opcode;

  // Register fields are decoded by the datapath, not here.
  logic       unused_ir_fields;

  assign opcode           = IR[IRW-1 -: 5];
  assign unused_ir_fields = ^IR[IRW-6:0];

  ctrl_decode u_decode (
    .opcode   (opcode),
    .op_class (op_class),
    .op_alu   (op_alu)
  );

  // Successor of the last step of any instruction; Stop is only looked at here.
  assign end_next = Stop ? ST_HALT : ST_T0;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= ST_RST;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RST:  state_next = ST_T0;
      ST_T0:   state_next = ST_T1;
      ST_T1,
      ST_T1W:  state_next = mem_rdy ? ST_T2 : ST_T1W;
      ST_T2:   state_next = ST_T3;
      ST_T3: begin
        case (op_class)
          CL_ALU3,
          CL_ALU2,
          CL_MULDIV: state_next = ST_T4;
          CL_HALT:   state_next = ST_HALT;
          CL_ILL:    state_next = (HALT_ON_ILLEGAL != 0) ? ST_HALT : end_next;
          default:   state_next = end_next;
        endcase
      end
      ST_T4: begin
        case (op_class)
          CL_ALU3,
          CL_MULDIV: state_next = ST_T5;
          default:   state_next = end_next;
        endcase
      end
      ST_T5:   state_next = (op_class == CL_MULDIV) ? ST_T6 : end_next;
      ST_T6:   state_next = end_next;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_RST;
    endcase
  end

  always_comb begin
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    PCin     = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    alu_op   = ALUOPW'(ALU_NONE);
    illegal  = 1'b0;
    Run      = (state != ST_RST) && (state != ST_HALT);

    case (state)
      ST_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zin    = 1'b1;
        alu_op = ALUOPW'(ALU_INC);
      end
      ST_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      // Memory wait: keep reading but never reload PC, so it advances once.
      ST_T1W: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        case (op_class)
          CL_ALU3: begin
            Grb  = 1'b1;
            Rout = 1'b1;
            Yin  = 1'b1;
          end
          CL_ALU2: begin
            Grb    = 1'b1;
            Rout   = 1'b1;
            Zin    = 1'b1;
            alu_op = ALUOPW'(op_alu);
          end
          CL_MULDIV: begin
            Gra  = 1'b1;
            Rout = 1'b1;
            Yin  = 1'b1;
          end
          CL_ILL:  illegal = 1'b1;
          default: ;
        endcase
      end
      ST_T4: begin
        case (op_class)
          CL_ALU3: begin
            Grc    = 1'b1;
            Rout   = 1'b1;
            Zin    = 1'b1;
            alu_op = ALUOPW'(op_alu);
          end
          CL_ALU2: begin
            Zlowout = 1'b1;
            Gra     = 1'b1;
            Rin     = 1'b1;
          end
          CL_MULDIV: begin
            Grb    = 1'b1;
            Rout   = 1'b1;
            Zin    = 1'b1;
            alu_op = ALUOPW'(op_alu);
          end
          default: ;
        endcase
      end
      ST_T5: begin
        case (op_class)
          CL_ALU3: begin
            Zlowout = 1'b1;
            Gra     = 1'b1;
            Rin     = 1'b1;
          end
          CL_MULDIV: begin
            Zlowout = 1'b1;
            LOin    = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T6: begin
        if (op_class == CL_MULDIV) begin
          Zhighout = 1'b1;
          HIin     = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        clk;
  logic        clr;
  logic [31:0] IR;
  logic        mem_rdy;
  logic        Stop;
  logic PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin;
  logic MDRout, IRin, Yin, HIin, LOin, Gra, Grb, Grc, Rin, Rout;
  logic [3:0]  alu_op;
  logic        Run;
  logic        illegal;

  control_unit dut (
    .clk(clk), .clr(clr), .IR(IR), .mem_rdy(mem_rdy), .Stop(Stop),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .HIin(HIin),
    .LOin(LOin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .alu_op(alu_op), .Run(Run), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe bit positions inside the 19-bit strobe field.
  localparam logic [18:0] S_PCOUT   = 19'b1 << 18;
  localparam logic [18:0] S_MARIN   = 19'b1 << 17;
  localparam logic [18:0] S_INCPC   = 19'b1 << 16;
  localparam logic [18:0] S_ZIN     = 19'b1 << 15;
  localparam logic [18:0] S_ZLOW    = 19'b1 << 14;
  localparam logic [18:0] S_ZHIGH   = 19'b1 << 13;
  localparam logic [18:0] S_PCIN    = 19'b1 << 12;
  localparam logic [18:0] S_READ    = 19'b1 << 11;
  localparam logic [18:0] S_MDRIN   = 19'b1 << 10;
  localparam logic [18:0] S_MDROUT  = 19'b1 << 9;
  localparam logic [18:0] S_IRIN    = 19'b1 << 8;
  localparam logic [18:0] S_YIN     = 19'b1 << 7;
  localparam logic [18:0] S_HIIN    = 19'b1 << 6;
  localparam logic [18:0] S_LOIN    = 19'b1 << 5;
  localparam logic [18:0] S_GRA     = 19'b1 << 4;
  localparam logic [18:0] S_GRB     = 19'b1 << 3;
  localparam logic [18:0] S_GRC     = 19'b1 << 2;
  localparam logic [18:0] S_RIN     = 19'b1 << 1;
  localparam logic [18:0] S_ROUT    = 19'b1 << 0;
  localparam logic [18:0] S_NONE    = 19'b0;

  // Hand-assigned ALU codes (NONE,ADD,SUB,AND,OR,SHR,SHRA,SHL,ROR,ROL,MUL,DIV,NEG,NOT,INC = 0..14).
  localparam logic [3:0] A_NONE = 4'd0;
  localparam logic [3:0] A_AND  = 4'd3;
  localparam logic [3:0] A_SHR  = 4'd5;
  localparam logic [3:0] A_MUL  = 4'd10;
  localparam logic [3:0] A_NEG  = 4'd12;
  localparam logic [3:0] A_INC  = 4'd14;

  localparam logic [31:0] IR_AND  = 32'h28918000;
  localparam logic [31:0] IR_SHR  = 32'h38918000;
  localparam logic [31:0] IR_ADD  = 32'h18918000;
  localparam logic [31:0] IR_NEG  = 32'h88900000;
  localparam logic [31:0] IR_MUL  = 32'h79000000;
  localparam logic [31:0] IR_NOP  = 32'hD0000000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;
  localparam logic [31:0] IR_ILL  = 32'hF8000000;

  typedef struct {
    logic [24:0] v;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [24:0] got;
  assign got = {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin,
                MDRout, IRin, Yin, HIin, LOin, Gra, Grb, Grc, Rin, Rout,
                alu_op, Run, illegal};

  // Monitor: one observation per cycle, taken on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e_mon = sb.pop_front();
      n_cmp++;
      if (got !== e_mon.v) begin
        n_bad++;
        $display("FAIL %s: got %h required %h (strobes|alu|run|ill)", e_mon.nm, got, e_mon.v);
      end
    end
  end

  // Queue the expected outputs for the current cycle, then advance one cycle.
  task automatic expect_cycle(input logic [18:0] m, input logic [3:0] a,
                              input logic run, input logic ill, input string nm);
    exp_t e;
    e.v  = {m, a, run, ill};
    e.nm = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input int waits, input string tag);
    mem_rdy = 1'b1;
    expect_cycle(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, A_INC, 1'b1, 1'b0, {tag, "_t0"});
    mem_rdy = (waits == 0);
    expect_cycle(S_ZLOW | S_PCIN | S_READ | S_MDRIN, A_NONE, 1'b1, 1'b0, {tag, "_t1"});
    for (int i = 1; i <= waits; i++) begin
      mem_rdy = (i == waits);
      expect_cycle(S_READ | S_MDRIN, A_NONE, 1'b1, 1'b0, {tag, "_t1w"});
    end
    mem_rdy = 1'b1;
    expect_cycle(S_MDROUT | S_IRIN, A_NONE, 1'b1, 1'b0, {tag, "_t2"});
  endtask

  task automatic reset_pulse(input string tag);
    clr = 1'b0;
    expect_cycle(S_NONE, A_NONE, 1'b0, 1'b0, {tag, "_rst"});
    clr = 1'b1;
    expect_cycle(S_NONE, A_NONE, 1'b0, 1'b0, {tag, "_rst_rel"});
  endtask

  initial begin
    clr     = 1'b0;
    IR      = 32'h0;
    mem_rdy = 1'b1;
    Stop    = 1'b0;
    @(posedge clk);
    #1;
    expect_cycle(S_NONE, A_NONE, 1'b0, 1'b0, "rst_hold");
    clr = 1'b1;
    expect_cycle(S_NONE, A_NONE, 1'b0, 1'b0, "rst_release");

    // and R1,R2,R3
    IR = IR_AND;
    do_fetch(0, "and");
    expect_cycle(S_GRB | S_ROUT | S_YIN, A_NONE, 1'b1, 1'b0, "and_t3");
    expect_cycle(S_GRC | S_ROUT | S_ZIN, A_AND, 1'b1, 1'b0, "and_t4");
    expect_cycle(S_ZLOW | S_GRA | S_RIN, A_NONE, 1'b1, 1'b0, "and_t5");

    // shr R1,R2,R3 with three memory-wait cycles
    IR = IR_SHR;
    do_fetch(3, "shr");
    expect_cycle(S_GRB | S_ROUT | S_YIN, A_NONE, 1'b1, 1'b0, "shr_t3");
    expect_cycle(S_GRC | S_ROUT | S_ZIN, A_SHR, 1'b1, 1'b0, "shr_t4");
    expect_cycle(S_ZLOW | S_GRA | S_RIN, A_NONE, 1'b1, 1'b0, "shr_t5");

    // neg R1,R2
    IR = IR_NEG;
    do_fetch(0, "neg");
    expect_cycle(S_GRB | S_ROUT | S_ZIN, A_NEG, 1'b1, 1'b0, "neg_t3");
    expect_cycle(S_ZLOW | S_GRA | S_RIN, A_NONE, 1'b1, 1'b0, "neg_t4");

    // nop
    IR = IR_NOP;
    do_fetch(0, "nop");
    expect_cycle(S_NONE, A_NONE, 1'b1, 1'b0, "nop_t3");

    // mul R2,R0 without Stop: returns to T0
    IR = IR_MUL;
    do_fetch(0, "mul");
    expect_cycle(S_GRA | S_ROUT | S_YIN, A_NONE, 1'b1, 1'b0, "mul_t3");
    expect_cycle(S_GRB | S_ROUT | S_ZIN, A_MUL, 1'b1, 1'b0, "mul_t4");
    expect_cycle(S_ZLOW | S_LOIN, A_NONE, 1'b1, 1'b0, "mul_t5");
    expect_cycle(S_ZHIGH | S_HIIN, A_NONE, 1'b1, 1'b0, "mul_t6");

    // mul again, Stop raised in T4 and held: runs to T6, then halts
    do_fetch(0, "mul2");
    expect_cycle(S_GRA | S_ROUT | S_YIN, A_NONE, 1'b1, 1'b0, "mul2_t3");
    Stop = 1'b1;
    expect_cycle(S_GRB | S_ROUT | S_ZIN, A_MUL, 1'b1, 1'b0, "mul2_t4");
    expect_cycle(S_ZLOW | S_LOIN, A_NONE, 1'b1, 1'b0, "mul2_t5");
    expect_cycle(S_ZHIGH | S_HIIN, A_NONE, 1'b1, 1'b0, "mul2_t6");
    for (int i = 0; i < 3; i++) expect_cycle(S_NONE, A_NONE, 1'b0, 1'b0, "stop_halt");
    Stop = 1'b0;
    expect_cycle(S_NONE, A_NONE, 1'b0, 1'b0, "stop_halt_hold");
    reset_pulse("after_stop");

    // halt instruction
    IR = IR_HALT;
    do_fetch(0, "halt");
    expect_cycle(S_NONE, A_NONE, 1'b1, 1'b0, "halt_t3");
    for (int i = 0; i < 20; i++) expect_cycle(S_NONE, A_NONE, 1'b0, 1'b0, "halted");
    reset_pulse("after_halt");

    // illegal opcode: single-cycle pulse, then next fetch
    IR = IR_ILL;
    do_fetch(0, "ill");
    expect_cycle(S_NONE, A_NONE, 1'b1, 1'b1, "ill_t3");

    // add interrupted by reset in T4
    IR = IR_ADD;
    do_fetch(0, "add");
    expect_cycle(S_GRB | S_ROUT | S_YIN, A_NONE, 1'b1, 1'b0, "add_t3");
    #1;
    clr = 1'b0;
    expect_cycle(S_NONE, A_NONE, 1'b0, 1'b0, "abort_async");
    expect_cycle(S_NONE, A_NONE, 1'b0, 1'b0, "abort_hold");
    clr = 1'b1;
    expect_cycle(S_NONE, A_NONE, 1'b0, 1'b0, "abort_release");
    IR = IR_NOP;
    do_fetch(0, "restart");
    expect_cycle(S_NONE, A_NONE, 1'b1, 1'b0, "restart_t3");

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
